vsa_dmem_io: RTL and testbench

VSA_DMEM_IO -- requirements
Module: vsa_dmem_io

---
 rtl/vsa_dmem_io_if.sv | 24 ++
 rtl/vsa_dmem_io.sv | 99 +++++++++
 tb/tb_vsa_dmem_io.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vsa_dmem_io_if.sv
// CPU data-memory bus plus the output/input stream handshakes of the I/O block.
// The slave modport is the memory/I-O side; the master modport drives it.
interface vsa_dmem_io_if;
    logic [4:0] addr;
    logic [4:0] wdata;
    logic       wr;
    logic [4:0] rdata;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_data;

    modport slave (
        input  addr, wdata, wr, out_ready, in_valid, in_data,
        output rdata, out_valid, out_data, in_ready
    );

    modport master (
        output addr, wdata, wr, out_ready, in_valid, in_data,
        input  rdata, out_valid, out_data, in_ready
    );
endinterface

// File: rtl/vsa_dmem_io.sv
// Data memory for the small CPU: 30-word RAM, memory-mapped output FIFO (addr 30)
// and single-entry input holding register (addr 31), with combinational reads.
module vsa_dmem_io #(
    parameter int OUT_DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    vsa_dmem_io_if.slave  bus
);
    localparam logic [2:0] DEPTH    = 3'(OUT_DEPTH);
    localparam logic [4:0] ADDR_OUT = 5'd30;
    localparam logic [4:0] ADDR_IN  = 5'd31;

    logic [4:0] r_mem  [0:29];
    logic [4:0] r_fifo [0:7];
    logic [2:0] r_wptr;
    logic [2:0] r_rptr;
    logic [2:0] r_count;
    logic       r_ovf;
    logic       r_in_full;
    logic [4:0] r_hold;

    logic       w_ram_wr;
    logic       w_pop;
    logic       w_push_req;
    logic       w_push;
    logic       w_drop;
    logic       w_ack;
    logic       w_capture;
    logic [4:0] w_rdata;

    function automatic logic [2:0] ptr_next(input logic [2:0] p);
        return (p == DEPTH - 3'd1) ? 3'd0 : p + 3'd1;
    endfunction

    assign w_ram_wr   = bus.wr && (bus.addr < ADDR_OUT);
    assign w_pop      = (r_count != 3'd0) && bus.out_ready;
    assign w_push_req = bus.wr && (bus.addr == ADDR_OUT);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push     = w_push_req && ((r_count < DEPTH) || w_pop);
    assign w_drop     = w_push_req && !w_push;
    assign w_ack      = bus.wr && (bus.addr == ADDR_IN);
    assign w_capture  = bus.in_valid && !r_in_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 30; i++) r_mem[i] <= '0;
        end else if (w_ram_wr) begin
            r_mem[bus.addr] <= bus.wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r_fifo[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= bus.wdata;
                r_wptr         <= ptr_next(r_wptr);
            end
            if (w_pop) r_rptr <= ptr_next(r_rptr);
            if (w_push && !w_pop)      r_count <= r_count + 3'd1;
            else if (!w_push && w_pop) r_count <= r_count - 3'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf     <= 1'b0;
            r_in_full <= 1'b0;
            r_hold    <= '0;
        end else begin
            if (w_ack && bus.wdata[0]) r_ovf <= 1'b0;
            else if (w_drop)           r_ovf <= 1'b1;
            // Acknowledge wins; capture is only possible while the register is empty.
            if (w_ack) begin
                r_in_full <= 1'b0;
            end else if (w_capture) begin
                r_hold    <= bus.in_data;
                r_in_full <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (bus.addr < ADDR_OUT)       w_rdata = r_mem[bus.addr];
        else if (bus.addr == ADDR_OUT) w_rdata = {r_ovf, r_in_full, r_count};
        else if (r_in_full)            w_rdata = r_hold;
    end

    assign bus.rdata     = w_rdata;
    assign bus.out_valid = (r_count != 3'd0);
    assign bus.out_data  = r_fifo[r_rptr];
    assign bus.in_ready  = !r_in_full;
endmodule

// File: tb/tb_vsa_dmem_io.sv
// Bench for vsa_dmem_io: directed scenarios plus randomized traffic against a
// queue/array reference model of the memory map.
module tb_vsa_dmem_io;
    localparam int DEPTH = 4;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_fail;

    vsa_dmem_io_if bus ();

    vsa_dmem_io #(.OUT_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #50 clock = ~clock;

    // Reference model
    logic [4:0] m_mem [30];
    logic [4:0] m_q [$];
    logic       m_ovf;
    logic       m_in_full;
    logic [4:0] m_hold;

    function automatic void model_clear();
        for (int i = 0; i < 30; i++) m_mem[i] = '0;
        m_q.delete();
        m_ovf     = 1'b0;
        m_in_full = 1'b0;
        m_hold    = '0;
    endfunction

    function automatic logic [4:0] exp_rdata(input logic [4:0] a);
        if (a < 5'd30)  return m_mem[a];
        if (a == 5'd30) return {m_ovf, m_in_full, 3'(m_q.size())};
        return m_in_full ? m_hold : 5'd0;
    endfunction

    function automatic void model_step();
        bit pop;
        bit push;
        pop  = (m_q.size() != 0) && bus.out_ready;
        push = 1'b0;
        if (bus.wr && bus.addr == 5'd30) begin
            if (m_q.size() < DEPTH || pop) push = 1'b1;
            else                           m_ovf = 1'b1;
        end
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(bus.wdata);
        if (bus.wr && bus.addr < 5'd30) m_mem[bus.addr] = bus.wdata;
        if (bus.wr && bus.addr == 5'd31) begin
            m_in_full = 1'b0;
            if (bus.wdata[0]) m_ovf = 1'b0;
        end else if (bus.in_valid && !m_in_full) begin
            m_hold    = bus.in_data;
            m_in_full = 1'b1;
        end
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".out_valid"}, 5'(bus.out_valid), 5'(m_q.size() != 0));
        if (m_q.size() != 0) check({tag, ".out_data"}, bus.out_data, m_q[0]);
        check({tag, ".in_ready"}, 5'(bus.in_ready), 5'(!m_in_full));
        check({tag, ".rdata"}, bus.rdata, exp_rdata(bus.addr));
    endtask

    task automatic tick();
        if (!reset) model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.wr = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    endtask

    task automatic scan_reads_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            bus.addr = 5'(a);
            #1;
            check(tag, bus.rdata, 5'd0);
        end
    endtask

    task automatic write(input logic [4:0] a, input logic [4:0] d);
        bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
        tick();
        bus.wr = 1'b0;
    endtask

    logic [4:0] r1;
    logic [4:0] r2;

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1;
        bus.addr = '0; bus.wdata = '0; bus.in_data = '0;
        idle();
        model_clear();
        #1;
        check("rst.out_valid", 5'(bus.out_valid), 5'd0);
        check("rst.out_data", bus.out_data, 5'd0);
        check("rst.in_ready", 5'(bus.in_ready), 5'd1);
        scan_reads_zero("rst.rdata");
        @(posedge clock); #1;
        reset = 1'b0;
        #1;

        // RAM write then read-back.
        write(5'd7, 5'h15);
        bus.addr = 5'd7; #1;
        check("ram7", bus.rdata, 5'h15);
        check_state("ram7m");
        bus.addr = 5'd8; #1;
        check("ram8", bus.rdata, 5'h00);

        // Overfill the output FIFO, then drain it.
        bus.out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) write(5'd30, 5'(v));
        bus.addr = 5'd30; #1;
        check("ovf.status", bus.rdata, 5'b10100);
        bus.out_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            #1;
            check("drain.valid", 5'(bus.out_valid), 5'd1);
            check("drain.data", bus.out_data, 5'(v));
            tick();
        end
        check("drain.empty", 5'(bus.out_valid), 5'd0);
        check("drain.status", bus.rdata, 5'b10000);

        // Clear ovf, fill, then push into a full FIFO while popping.
        write(5'd31, 5'h01);
        bus.out_ready = 1'b0;
        for (int v = 5; v <= 8; v++) write(5'd30, 5'(v));
        bus.out_ready = 1'b1;
        write(5'd30, 5'd9);
        bus.out_ready = 1'b0;
        bus.addr = 5'd30; #1;
        check("fullpop.status", bus.rdata, 5'b00100);
        check_state("fullpop");
        bus.out_ready = 1'b1;
        for (int v = 6; v <= 9; v++) begin
            #1;
            check("fullpop.data", bus.out_data, 5'(v));
            tick();
        end
        check("fullpop.empty", 5'(bus.out_valid), 5'd0);
        bus.out_ready = 1'b0;

        // Input holding register: capture, ignore second offer, acknowledge.
        write(5'd31, 5'h00);
        bus.in_valid = 1'b1; bus.in_data = 5'h0B;
        tick();
        bus.in_data = 5'h1F;
        bus.addr = 5'd31; #1;
        check("in.ready", 5'(bus.in_ready), 5'd0);
        check("in.hold", bus.rdata, 5'h0B);
        bus.addr = 5'd30; #1;
        check("in.status", 5'(bus.rdata[3]), 5'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.addr = 5'd31; #1;
        check("in.ignored", bus.rdata, 5'h0B);
        bus.out_ready = 1'b0;
        write(5'd30, 5'd1); write(5'd30, 5'd2); write(5'd30, 5'd3);
        write(5'd30, 5'd4); write(5'd30, 5'd5);
        write(5'd31, 5'h01);
        bus.addr = 5'd30; #1;
        check("ack.status", bus.rdata, 5'b00100);
        check("ack.ready", 5'(bus.in_ready), 5'd1);
        check_state("ack");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4)      bus.addr = 5'd30;
            else if (sel < 6) bus.addr = 5'd31;
            else              bus.addr = 5'($urandom_range(0, 29));
            bus.wr        = ($urandom_range(0, 1) == 1);
            bus.wdata     = 5'($urandom);
            bus.out_ready = ($urandom_range(0, 2) == 0);
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.in_data   = 5'($urandom);
            #1;
            check_state("rand");
            tick();
        end
        idle();

        // Reset in the middle of traffic with count=3 and in_full=1.
        reset = 1'b1; #1; model_clear(); @(posedge clock); #1; reset = 1'b0; #1;
        for (int v = 1; v <= 3; v++) write(5'd30, 5'(v + 10));
        bus.in_valid = 1'b1; bus.in_data = 5'h12;
        tick();
        bus.addr = 5'd30; #1;
        check("pre.status", bus.rdata, 5'b01011);
        bus.wr = 1'b1; bus.addr = 5'd30; bus.wdata = 5'h1E;
        #20;
        reset = 1'b1;
        #1;
        model_clear();
        check("mid.out_valid", 5'(bus.out_valid), 5'd0);
        check("mid.in_ready", 5'(bus.in_ready), 5'd1);
        check("mid.out_data", bus.out_data, 5'd0);
        scan_reads_zero("mid.rdata");
        idle();
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check_state("post");
        write(5'd3, 5'h1A);
        bus.addr = 5'd3; #1;
        check("first.ram3", bus.rdata, 5'h1A);
        bus.addr = 5'd30; #1;
        check("post.status", bus.rdata, 5'd0);

        // SW r1,3(r0); LW r2,3(r0).
        r1 = 5'($urandom_range(1, 31));
        write(5'd3, r1);
        bus.addr = 5'd3; #1;
        r2 = bus.rdata;
        tick();
        check("lw_sw", r2, r1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
